// File: rtl/qsn_pipe.sv
// qsn_pipe: pipelined Z x W quasi-cyclic rotator, one barrel stage per register; `QSN_REVERSE_EN adds in_dir
module qsn_pipe #(
  parameter int Z = 4,
  parameter int W = 1,
  parameter int SW = $clog2(Z)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z*W-1:0] in_data,
  input  logic [SW-1:0]  in_shift,
`ifdef QSN_REVERSE_EN
  input  logic           in_dir,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Z*W-1:0] out_data
);
  logic [SW-1:0] v_q, ld, pv, pr;
  logic [Z*W-1:0] d_q [SW];
  logic [Z*W-1:0] pd [SW];
  logic [SW-1:0] s_q [SW];
  logic [SW-1:0] ps [SW];
  logic e;
`ifdef QSN_REVERSE_EN
  logic r_q [SW];
`endif
  function automatic logic [Z*W-1:0] rot(input logic [Z*W-1:0] d, input int r, input logic rev);
    logic [Z*W-1:0] o;
    o = '0;
    for (int i = 0; i < Z; i++)
      o[i*W +: W] = rev ? d[((i + Z - r) % Z)*W +: W] : d[((i + r) % Z)*W +: W];
    return o;
  endfunction
  // a stage may load if it or any stage downstream of it is empty, or the sink takes the head
  always_comb begin
    ld = '0;
    e = 1'b0;
    for (int k = 0; k < SW; k++) begin
      e = out_ready;
      for (int j = k; j < SW; j++) e = e || !v_q[j];
      ld[k] = e;
    end
  end
  always_comb begin
    pv = '0;
    pr = '0;
    pd = '{default: '0};
    ps = '{default: '0};
    pv[0] = in_valid;
    pd[0] = in_data;
    ps[0] = in_shift;
`ifdef QSN_REVERSE_EN
    pr[0] = in_dir;
`endif
    for (int k = 1; k < SW; k++) begin
      pv[k] = v_q[k-1];
      pd[k] = d_q[k-1];
      ps[k] = s_q[k-1];
`ifdef QSN_REVERSE_EN
      pr[k] = r_q[k-1];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < SW; k++) begin
        d_q[k] <= '0;
        s_q[k] <= '0;
`ifdef QSN_REVERSE_EN
        r_q[k] <= 1'b0;
`endif
      end
    end else
      for (int k = 0; k < SW; k++)
        if (ld[k]) begin
          v_q[k] <= pv[k];
          if (pv[k]) begin
            d_q[k] <= ps[k][k] ? rot(pd[k], (1 << k) % Z, pr[k]) : pd[k];
            s_q[k] <= ps[k];
`ifdef QSN_REVERSE_EN
            r_q[k] <= pr[k];
`endif
          end
        end
  assign in_ready  = ld[0];
  assign out_valid = v_q[SW-1];
  assign out_data  = d_q[SW-1];
endmodule

// File: tb/tb_qsn_pipe.sv
// tb_qsn_pipe: scoreboard bench for qsn_pipe at Z=4/W=1 and Z=6/W=8
module tb_qsn_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_iv, a_ir, a_ov, a_or, a_dir;
  logic [3:0] a_id, a_od;
  logic [1:0] a_is;
  logic b_iv, b_ir, b_ov, b_or, b_dir;
  logic [47:0] b_id, b_od;
  logic [2:0] b_is;

  int checks = 0;
  int errors = 0;
  logic [3:0] qa [$];
  logic [47:0] qb [$];
  logic [3:0] xa;
  logic [47:0] xb;

  qsn_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_shift(a_is),
`ifdef QSN_REVERSE_EN
    .in_dir(a_dir),
`endif
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
  );

  qsn_pipe #(.Z(6), .W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_shift(b_is),
`ifdef QSN_REVERSE_EN
    .in_dir(b_dir),
`endif
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
  );

  function automatic logic [3:0] ea(input logic [3:0] d, input int s, input logic rev);
    logic [3:0] o;
    int j;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      j = rev ? (i - s % 4 + 4) % 4 : (i + s) % 4;
      o[i] = d[j];
    end
    return o;
  endfunction

  function automatic logic [47:0] eb(input logic [47:0] d, input int s, input logic rev);
    logic [47:0] o;
    int j;
    o = '0;
    for (int i = 0; i < 6; i++) begin
      j = rev ? (i - s % 6 + 6) % 6 : (i + s) % 6;
      o[i*8 +: 8] = d[j*8 +: 8];
    end
    return o;
  endfunction

  // scoreboard: pop on output transfer, push on input transfer
  always @(negedge clk)
    if (rst_n) begin
      if (a_ov && a_or) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_extra got=%h expected=none", a_od);
        end else begin
          xa = qa.pop_front();
          if (a_od !== xa) begin
            errors++;
            $display("FAIL a_data got=%h expected=%h", a_od, xa);
          end
        end
      end
      if (a_iv && a_ir) qa.push_back(ea(a_id, int'(a_is), a_dir));
      if (b_ov && b_or) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_extra got=%h expected=none", b_od);
        end else begin
          xb = qb.pop_front();
          if (b_od !== xb) begin
            errors++;
            $display("FAIL b_data got=%h expected=%h", b_od, xb);
          end
        end
      end
      if (b_iv && b_ir) qb.push_back(eb(b_id, int'(b_is), b_dir));
    end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b expected=0", a_ov); end
    if (a_od !== 4'h0) begin errors++; $display("FAIL rst_a_data got=%h expected=0", a_od); end
    if (b_ov !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b expected=0", b_ov); end
    if (b_od !== 48'h0) begin errors++; $display("FAIL rst_b_data got=%h expected=0", b_od); end
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (a_ir !== 1'b1) begin errors++; $display("FAIL rst_a_ready got=%b expected=1", a_ir); end
    if (b_ir !== 1'b1) begin errors++; $display("FAIL rst_b_ready got=%b expected=1", b_ir); end
  endtask

  task automatic test_latency;
    logic [3:0] din [2];
    logic [3:0] dexp [2];
    logic [1:0] sh [2];
    din[0] = 4'b0001; sh[0] = 2'd1; dexp[0] = 4'b1000;
    din[1] = 4'b0110; sh[1] = 2'd0; dexp[1] = 4'b0110;
    a_or = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick;
      a_iv = 1'b1; a_id = din[t]; a_is = sh[t];
      @(negedge clk);
      checks++;
      if (a_ir !== 1'b1) begin errors++; $display("FAIL lat_accept got=%b expected=1", a_ir); end
      tick;
      a_iv = 1'b0;
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b0) begin errors++; $display("FAIL lat_early got=%b expected=0", a_ov); end
      tick;
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b1 || a_od !== dexp[t])
        begin errors++; $display("FAIL lat_out got=%b/%b expected=1/%b", a_ov, a_od, dexp[t]); end
    end
  endtask

  task automatic test_z6;
    int n;
    b_or = 1'b1;
    tick;
    b_iv = 1'b1; b_id = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}; b_is = 3'd7;
    tick;
    b_is = 3'd5;
    tick;
    b_iv = 1'b0;
    n = 0;
    while (!b_ov && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (b_ov !== 1'b1 || b_od !== {8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1})
      begin errors++; $display("FAIL z6_s7 got=%b/%h expected=1/000504030201", b_ov, b_od); end
    @(negedge clk);
    checks++;
    if (b_ov !== 1'b1 || b_od !== {8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5})
      begin errors++; $display("FAIL z6_s5 got=%b/%h expected=1/040302010005", b_ov, b_od); end
    for (int t = 0; t < 8; t++) begin
      tick;
      b_iv = 1'b1; b_id = 48'({$urandom(), $urandom()}); b_is = 3'($urandom_range(0, 7));
    end
    tick;
    b_iv = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    a_or = 1'b1;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          tick;
          a_iv = 1'b1; a_id = 4'($urandom()); a_is = 2'($urandom_range(0, 3));
        end
        tick;
        a_iv = 1'b0;
      end
      begin
        int n;
        int run;
        n = 0;
        run = 0;
        while (!a_ov && n < 30) begin @(negedge clk); n++; end
        while (a_ov && run < 30) begin run++; @(negedge clk); end
        checks++;
        if (run != 8) begin errors++; $display("FAIL b2b_run got=%0d expected=8", run); end
      end
    join
  endtask

  task automatic test_stall;
    int acc;
    int n;
    logic [3:0] nxt;
    logic [3:0] held;
    acc = 0;
    nxt = 4'h3;
    a_or = 1'b0;
    a_is = 2'd3;
    for (int t = 0; t < 6; t++) begin
      tick;
      a_iv = 1'b1; a_id = nxt;
      @(negedge clk);
      if (a_ir) begin acc++; nxt++; end
    end
    checks += 2;
    if (acc != 2) begin errors++; $display("FAIL stall_count got=%0d expected=2", acc); end
    if (a_ir !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b expected=0", a_ir); end
    held = a_od;
    for (int t = 0; t < 3; t++) begin
      tick;
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b1 || a_od !== held)
        begin errors++; $display("FAIL stall_hold got=%b/%h expected=1/%h", a_ov, a_od, held); end
    end
    tick;
    a_or = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ir !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b expected=1", a_ir); end
    tick;
    a_iv = 1'b0;
    n = 0;
    while ((qa.size() != 0 || a_ov) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (qa.size() != 0) begin errors++; $display("FAIL stall_drain got=%0d expected=0", qa.size()); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    tick;
    a_or = 1'b0;
    a_iv = 1'b1; a_id = 4'hA; a_is = 2'd1;
    tick;
    a_id = 4'h5;
    tick;
    a_iv = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ov !== 1'b1) begin errors++; $display("FAIL mid_full got=%b expected=1", a_ov); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    qa.delete();
    #1;
    checks += 2;
    if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b expected=0", a_ov); end
    if (a_od !== 4'h0) begin errors++; $display("FAIL mid_data got=%h expected=0", a_od); end
    repeat (2) tick;
    rst_n = 1'b1;
    a_or = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (a_ov) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b expected=0", seen); end
  endtask

`ifdef QSN_REVERSE_EN
  task automatic test_reverse;
    int n;
    logic [3:0] d;
    logic [3:0] y;
    int s;
    a_or = 1'b1;
    tick;
    a_iv = 1'b1; a_id = 4'b0001; a_is = 2'd1; a_dir = 1'b1;
    tick;
    a_iv = 1'b0;
    n = 0;
    while (!a_ov && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (a_ov !== 1'b1 || a_od !== 4'b0010)
      begin errors++; $display("FAIL rev_basic got=%b/%b expected=1/0010", a_ov, a_od); end
    for (int t = 0; t < 6; t++) begin
      d = 4'($urandom());
      s = $urandom_range(0, 3);
      tick;
      a_iv = 1'b1; a_id = d; a_is = s[1:0]; a_dir = 1'b0;
      tick;
      a_iv = 1'b0;
      n = 0;
      while (!a_ov && n < 10) begin @(negedge clk); n++; end
      y = a_od;
      tick;
      a_iv = 1'b1; a_id = y; a_dir = 1'b1;
      tick;
      a_iv = 1'b0;
      n = 0;
      while (!a_ov && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (a_ov !== 1'b1 || a_od !== d)
        begin errors++; $display("FAIL rev_roundtrip got=%b/%h expected=1/%h", a_ov, a_od, d); end
    end
    tick;
    a_dir = 1'b0;
  endtask
`endif

  initial begin
    a_iv = 1'b0; a_or = 1'b0; a_id = '0; a_is = '0; a_dir = 1'b0;
    b_iv = 1'b0; b_or = 1'b0; b_id = '0; b_is = '0; b_dir = 1'b0;
    test_reset;
    test_latency;
    test_z6;
    test_back_to_back;
    test_stall;
    test_reset_mid;
`ifdef QSN_REVERSE_EN
    test_reverse;
`endif
    repeat (6) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      begin errors++; $display("FAIL final_drain got=%0d/%0d expected=0/0", qa.size(), qb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
